// File: rtl/cpu_step_ctrl_pkg.sv
// Shared OSECPU step-controller definitions: mode encodings and counter sizing.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } step_state_e;

  localparam int unsigned STEP_CNT_W = 16;

  // Bits needed to hold a count of 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Raw button -> 2-flop synchronizer -> debouncer -> one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEB_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEB_BITS > 0) ? DEB_BITS : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((64'd1 << DEB_BITS) - 64'd1);

  logic [1:0]    sync_q, sync_d;
  logic [1:0]    vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          prev_q, prev_d;
  logic          armed_q, armed_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    vld_d   = {vld_q[0], 1'b1};
    cnt_d   = '0;
    lvl_d   = lvl_q;
    prev_d  = lvl_q;
    // Only a genuinely sampled low arms the press detector, so a button held
    // through reset cannot fire until it has been released once.
    armed_d = armed_q | (vld_q[1] & ~sync_q[1]);
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign press_o = lvl_q & ~prev_q & armed_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU run/halt/single-step controller: gates the CPU clock-enable from two buttons.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DIV_BIT    = 24,
  parameter int unsigned POR_CYCLES = 16,
  parameter int unsigned DEB_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_run,
  input  logic                  btn_step,
  input  logic                  cpu_halted,
  output logic                  cpu_reset,
  output logic                  cpu_ce,
  output logic [1:0]            mode,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam int unsigned DW = (DIV_BIT > 0) ? DIV_BIT : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((64'd1 << DIV_BIT) - 64'd1);
  localparam int unsigned PW = cnt_width(POR_CYCLES);
  localparam logic [PW-1:0] POR_LAST = PW'((POR_CYCLES > 0) ? POR_CYCLES - 1 : 0);

  step_state_e           state_q, state_d;
  logic [PW-1:0]         por_q, por_d;
  logic [DW-1:0]         div_q, div_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  run_evt, step_evt;
  logic                  div_full;

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_run (
    .clk_i  (clk),
    .rst_i  (reset),
    .btn_i  (btn_run),
    .press_o(run_evt)
  );

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_step (
    .clk_i  (clk),
    .rst_i  (reset),
    .btn_i  (btn_step),
    .press_o(step_evt)
  );

  // With DIV_BIT=0 the last value is 0, so the divider sits at 0 and fires every cycle.
  assign div_full = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    por_d     = '0;
    div_d     = '0;
    cnt_d     = cnt_q;
    cpu_reset = 1'b0;
    cpu_ce    = 1'b0;
    unique case (state_q)
      ST_POR: begin
        cpu_reset = 1'b1;
        if (por_q == POR_LAST) begin
          state_d = ST_HALT;
        end else begin
          por_d = por_q + PW'(1);
        end
      end
      ST_HALT: begin
        if (run_evt) begin
          state_d = ST_RUN;
        end else if (step_evt) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        div_d  = div_full ? '0 : div_q + DW'(1);
        cpu_ce = div_full & ~cpu_halted;
        if (run_evt || cpu_halted) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        cpu_ce  = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_POR;
    endcase
    if (cpu_ce) begin
      cnt_d = cnt_q + STEP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_POR;
      por_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      por_q   <= por_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode       = state_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: per-cycle expectations from a behavioural model.
module tb_cpu_step_ctrl;

  localparam int DIVB = 2;
  localparam int PORC = 4;
  localparam int DEBB = 2;
  localparam int DIVP = 1 << DIVB;
  localparam int DEBL = 1 << DEBB;
  localparam int MAXC = 16384;
  localparam int M_POR = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;

  logic        clk = 1'b0;
  logic        reset, btn_run, btn_step, cpu_halted;
  logic        cpu_reset, cpu_ce;
  logic [1:0]  mode;
  logic [15:0] step_count;

  logic        w_reset, w_btn_run;
  logic        w_cpu_reset, w_cpu_ce;
  logic [1:0]  w_mode;
  logic [15:0] w_step_count;

  typedef struct { logic rst; logic ce; logic [1:0] md; logic [15:0] cnt; } exp_t;
  typedef struct { int cyc; logic [1:0] md; logic [15:0] cnt; } wexp_t;

  exp_t  exp_q[$];
  wexp_t wexp_q[$];
  exp_t  mon_e;
  wexp_t mon_w;
  int    n_vec = 0;
  int    n_bad = 0;
  bit    wrap_done = 1'b0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DIV_BIT(DIVB), .POR_CYCLES(PORC), .DEB_BITS(DEBB)) dut (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
    .cpu_halted(cpu_halted), .cpu_reset(cpu_reset), .cpu_ce(cpu_ce),
    .mode(mode), .step_count(step_count)
  );

  // Second instance runs flat out so the 16-bit step counter wraps in bounded time.
  cpu_step_ctrl #(.DIV_BIT(0), .POR_CYCLES(1), .DEB_BITS(1)) dut_wrap (
    .clk(clk), .reset(w_reset), .btn_run(w_btn_run), .btn_step(1'b0),
    .cpu_halted(1'b0), .cpu_reset(w_cpu_reset), .cpu_ce(w_cpu_ce),
    .mode(w_mode), .step_count(w_step_count)
  );

  // Behavioural model state (driver process only)
  int m_mode, m_por, m_run, m_cnt, m_c;
  bit m_lvl[2], m_prev[2], m_arm[2];
  bit raw[2][MAXC];
  bit c_rst, c_run, c_step, c_halt;

  function automatic void model_reset();
    m_mode = M_POR; m_por = 0; m_run = 0; m_cnt = 0; m_c = 0;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0; m_prev[i] = 1'b0; m_arm[i] = 1'b0;
    end
  endfunction

  // Synchronized sample seen in cycle c is the raw input two cycles earlier.
  function automatic bit sync_at(input int i, input int c);
    if (c < 2) return 1'b0;
    return raw[i][c-2];
  endfunction

  task automatic tick();
    bit   evt_run, evt_step, ce, flip;
    bit   b[2];
    exp_t e;
    @(posedge clk); #1;
    reset = c_rst; btn_run = c_run; btn_step = c_step; cpu_halted = c_halt;
    evt_run  = m_lvl[0] && !m_prev[0] && m_arm[0];
    evt_step = m_lvl[1] && !m_prev[1] && m_arm[1];
    ce = (m_mode == M_STEP) || (m_mode == M_RUN && (m_run % DIVP) == DIVP - 1 && !c_halt);
    e.rst = (m_mode == M_POR); e.ce = ce; e.md = 2'(m_mode); e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
    if (c_rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_POR:  begin m_por++; if (m_por == PORC) m_mode = M_HALT; end
        M_HALT: begin
          if (evt_run) begin m_mode = M_RUN; m_run = 0; end
          else if (evt_step) m_mode = M_STEP;
        end
        M_RUN:  begin if (evt_run || c_halt) m_mode = M_HALT; else m_run++; end
        default: m_mode = M_HALT;
      endcase
      if (ce) m_cnt = (m_cnt + 1) % 65536;
      b[0] = c_run; b[1] = c_step;
      for (int i = 0; i < 2; i++) begin
        raw[i][m_c] = b[i];
        flip = 1'b1;
        for (int k = 0; k < DEBL; k++) if (sync_at(i, m_c - k) == m_lvl[i]) flip = 1'b0;
        if (m_c >= 2 && !sync_at(i, m_c)) m_arm[i] = 1'b1;
        m_prev[i] = m_lvl[i];
        if (flip) m_lvl[i] = !m_lvl[i];
      end
      if (m_c < MAXC - 1) m_c++;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (cpu_reset !== mon_e.rst || cpu_ce !== mon_e.ce || mode !== mon_e.md ||
          step_count !== mon_e.cnt) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got rst=%b ce=%b mode=%0d cnt=%h, expected rst=%b ce=%b mode=%0d cnt=%h",
                 $time, cpu_reset, cpu_ce, mode, step_count,
                 mon_e.rst, mon_e.ce, mon_e.md, mon_e.cnt);
      end
    end
    if (wexp_q.size() > 0) begin
      mon_w = wexp_q.pop_front();
      n_vec++;
      if (w_mode !== mon_w.md || w_step_count !== mon_w.cnt) begin
        n_bad++;
        $display("FAIL wrap c=%0d: got mode=%0d cnt=%h, expected mode=%0d cnt=%h",
                 mon_w.cyc, w_mode, w_step_count, mon_w.md, mon_w.cnt);
      end
    end
  end

  initial begin
    wexp_t we;
    w_reset = 1'b1; w_btn_run = 1'b0;
    for (int c = -3; c <= 65550; c++) begin
      @(posedge clk); #1;
      w_reset   = (c < 0);
      w_btn_run = (c >= 5);
      if (c == 8 || c == 9 || c == 10 || c == 11 || c == 65545 || c == 65546 || c == 65547) begin
        we.cyc = c;
        we.md  = (c >= 10) ? 2'd2 : 2'd1;
        we.cnt = (c >= 10) ? 16'(c - 10) : 16'd0;
        wexp_q.push_back(we);
      end
    end
    wrap_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors so far", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0; cpu_halted = 1'b0;
    c_rst = 1'b1; c_run = 1'b0; c_step = 1'b0; c_halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    hold(3);
    c_rst = 1'b0; hold(104);
    // single step, then a glitch too short to pass the debouncer
    c_step = 1'b1; hold(10); c_step = 1'b0; hold(20);
    c_step = 1'b1; hold(3);  c_step = 1'b0; hold(20);
    // run for several divider periods
    c_run = 1'b1; hold(10); c_run = 1'b0; hold(30);
    for (int k = 0; k < 40 && !(m_mode == M_RUN && (m_run % DIVP) == DIVP - 1); k++) hold(1);
    c_halt = 1'b1; hold(1); c_halt = 1'b0; hold(10);
    // simultaneous run and step presses
    c_run = 1'b1; c_step = 1'b1; hold(10); c_run = 1'b0; c_step = 1'b0; hold(25);
    c_run = 1'b1; hold(8); c_run = 1'b0; hold(10);
    // reset in the middle of RUN
    c_run = 1'b1; hold(8); c_run = 1'b0; hold(9);
    c_rst = 1'b1; hold(1); c_rst = 1'b0; hold(12);
    // button held through reset release
    c_run = 1'b1; hold(6); c_rst = 1'b1; hold(2); c_rst = 1'b0; hold(30);
    c_run = 1'b0; hold(15); c_run = 1'b1; hold(8); c_run = 1'b0; hold(20);
    c_halt = 1'b1; hold(2); c_halt = 1'b0; hold(5);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) c_run = !c_run;
      if ($urandom_range(0, 9) == 0) c_step = !c_step;
      c_halt = ($urandom_range(0, 40) == 0);
      c_rst  = ($urandom_range(0, 499) == 0);
      hold(1);
    end
    c_rst = 1'b0; c_halt = 1'b0; hold(5);
    wait (wrap_done);
    @(negedge clk); @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
